// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS/MOSI in the clk domain, deframes MOSI into
// words on a valid/ready stream and serialises words from a valid/ready stream
// onto MISO. CPOL/CPHA are latched at the start of every frame.
module spi_slave #(
    parameter int DATA_WIDTH    = 16,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  frame_error,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    input  logic                  spi_sck,
    output logic                  spi_miso
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(DATA_WIDTH - 1);

    // Synchroniser and history stages
    logic sck_meta, sck_sync, sck_hist;
    logic cs_meta, cs_sync, cs_hist;
    logic mosi_meta, mosi_sync;

    // Frame state
    state_t                   state;
    logic                     cpol_latched;
    logic                     cpha_latched;
    logic                     word_seen;
    logic [COUNTER_WIDTH-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0]    rx_shift;
    logic [DATA_WIDTH-1:0]    tx_shift;

    // Detected events, all one clk wide
    logic cs_fall, cs_rise;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;

    // Two-flop synchronisers on the SPI pins plus a history flop for edge detection
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops update from pre-edge values.
        if (reset) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_hist  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_hist   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_hist  <= sck_sync;
            cs_meta   <= spi_cs;
            cs_sync   <= cs_meta;
            cs_hist   <= cs_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign cs_fall     = cs_hist && !cs_sync;
    assign cs_rise     = !cs_hist && cs_sync;
    assign lead_edge   = (sck_hist == cpol_latched) && (sck_sync != cpol_latched);
    assign trail_edge  = (sck_hist != cpol_latched) && (sck_sync == cpol_latched);
    assign sample_edge = cpha_latched ? trail_edge : lead_edge;
    assign shift_edge  = cpha_latched ? lead_edge : trail_edge;

    // Frame FSM with RX deframing, TX serialisation and registered status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cpol_latched <= 1'b0;
            cpha_latched <= 1'b0;
            word_seen    <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_overrun   <= 1'b0;
            tx_ready     <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_error  <= 1'b0;
            spi_miso     <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each one lasts exactly one cycle.
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_error <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            spi_miso <= (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;

            case (state)
                IDLE: begin
                    if (enable && cs_fall) begin
                        state        <= ACTIVE;
                        cpol_latched <= spi_cpol;
                        cpha_latched <= spi_cpha;
                        word_seen    <= 1'b0;
                        bit_cnt      <= '0;
                        rx_shift     <= '0;
                        if (!spi_cpha) begin
                            // CPHA=0 must present the first bit before the first SCK edge
                            tx_ready    <= 1'b1;
                            tx_underrun <= !tx_valid;
                            tx_shift    <= tx_valid ? tx_data : '0;
                        end else begin
                            tx_shift <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    if (!enable) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                    end else if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                        rx_shift <= '0;
                        if (bit_cnt != '0) begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt    <= '0;
                                word_seen  <= 1'b1;
                                rx_data    <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
                                rx_valid   <= 1'b1;
                                rx_overrun <= rx_valid && !rx_ready;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (bit_cnt == '0 && (cpha_latched || word_seen)) begin
                                tx_ready    <= 1'b1;
                                tx_underrun <= !tx_valid;
                                tx_shift    <= tx_valid ? tx_data : '0;
                            end else begin
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as the SPI master, keeps a scoreboard of
// expected RX words and counts the one-cycle status pulses.
module tb_spi_slave;

    localparam int W    = 16;
    localparam int HALF = 5;   // SCK half-period in clk cycles

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         rx_ready;
    logic         rx_overrun;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic         tx_underrun;
    logic         frame_error;
    logic         spi_cpol;
    logic         spi_cpha;
    logic         spi_cs;
    logic         spi_mosi;
    logic         spi_sck;
    logic         spi_miso;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] rx_expq[$];
    logic [W-1:0] miso_words[$];

    int   n_ready = 0;
    int   n_under = 0;
    int   n_ovr   = 0;
    int   n_ferr  = 0;
    int   n_rxv   = 0;
    logic rxv_q   = 1'b0;
    int   ready_at_last_sample = 0;

    spi_slave #(.DATA_WIDTH(W), .COUNTER_WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .frame_error (frame_error),
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_sck     (spi_sck),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse counters and scoreboard pop, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_ready)    n_ready++;
        if (tx_underrun) n_under++;
        if (rx_overrun)  n_ovr++;
        if (frame_error) n_ferr++;
        if (rx_valid && !rxv_q) n_rxv++;
        rxv_q = rx_valid;
        if (!reset && rx_valid && rx_ready) begin
            checks++;
            assert (rx_expq.size() != 0)
            else begin
                failures++;
                $error("FAIL rx_unexpected observed=0x%0h expected=none", rx_data);
            end
            if (rx_expq.size() != 0) check("rx_word", 32'(rx_data), 32'(rx_expq.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: drives nbits of words (MSB first), captures MISO into miso_words
    task automatic spi_frame(input logic cpol, input logic cpha,
                             input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input int nbits, input bit release_cs);
        logic [2*W-1:0] stream;
        logic [W-1:0]   cap;
        stream = {w0, w1};
        cap    = '0;
        spi_cpol = cpol;
        spi_cpha = cpha;
        spi_sck  = cpol;
        wait_clk(4);
        spi_cs = 1'b0;
        if (!cpha) spi_mosi = stream[2*W-1];
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                cap = {cap[W-2:0], spi_miso};
                spi_sck = ~cpol;
                wait_clk(HALF);
                if (i == nbits - 1) ready_at_last_sample = n_ready;
                spi_sck = cpol;
                if (i + 1 < nbits) spi_mosi = stream[2*W-2-i];
                wait_clk(HALF);
            end else begin
                spi_sck  = ~cpol;
                spi_mosi = stream[2*W-1-i];
                wait_clk(HALF);
                cap = {cap[W-2:0], spi_miso};
                spi_sck = cpol;
                wait_clk(HALF);
            end
            if (i % W == W - 1) miso_words.push_back(cap);
        end
        wait_clk(6);
        if (release_cs) begin
            spi_cs = 1'b1;
            wait_clk(8);
        end
    endtask

    initial begin
        int snap_a;
        int snap_b;

        reset    = 1'b1;
        enable   = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 16'h1234;
        spi_cpol = 1'b0;
        spi_cpha = 1'b0;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(4);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd0);
        check("reset_miso", 32'(spi_miso), 32'd0);
        reset = 1'b0;
        wait_clk(4);

        // Mode 0, one word, TX held valid
        snap_a = n_rxv;
        snap_b = n_ready;
        rx_expq.push_back(16'hA5C3);
        spi_frame(1'b0, 1'b0, 16'hA5C3, 16'h0000, 16, 1'b1);
        check("m0_rx_valid_pulses", 32'(n_rxv - snap_a), 32'd1);
        check("m0_rx_data", 32'(rx_data), 32'hA5C3);
        check("m0_miso_word", 32'(miso_words.pop_front()), 32'h1234);
        // The final SCK return also prefetches the next word, so count strobes up to the last sample
        check("m0_tx_ready_strobes", 32'(ready_at_last_sample - snap_b), 32'd1);
        check("m0_scoreboard_drained", 32'(rx_expq.size()), 32'd0);

        // Modes 1..3, two back-to-back words in one frame
        for (int m = 1; m < 4; m++) begin
            snap_a = n_ferr;
            miso_words.delete();
            rx_expq.push_back(16'h8001);
            rx_expq.push_back(16'h7FFE);
            spi_frame(1'(m >> 1), 1'(m & 1), 16'h8001, 16'h7FFE, 32, 1'b1);
            check($sformatf("mode%0d_frame_error", m), 32'(n_ferr - snap_a), 32'd0);
            check($sformatf("mode%0d_drained", m), 32'(rx_expq.size()), 32'd0);
            check($sformatf("mode%0d_miso_w0", m), 32'(miso_words.pop_front()), 32'h1234);
            check($sformatf("mode%0d_miso_w1", m), 32'(miso_words.pop_front()), 32'h1234);
        end

        // Consumer stalled across two words
        miso_words.delete();
        rx_ready = 1'b0;
        snap_a   = n_ovr;
        spi_frame(1'b0, 1'b0, 16'h0001, 16'h0002, 32, 1'b1);
        check("ovr_pulses", 32'(n_ovr - snap_a), 32'd1);
        check("ovr_rx_data", 32'(rx_data), 32'h0002);
        check("ovr_rx_valid_held", 32'(rx_valid), 32'd1);
        rx_expq.push_back(16'h0002);
        rx_ready = 1'b1;
        wait_clk(4);
        check("ovr_drained", 32'(rx_expq.size()), 32'd0);
        check("ovr_rx_valid_cleared", 32'(rx_valid), 32'd0);

        // TX underrun (mode 1: exactly one load per word)
        miso_words.delete();
        tx_valid = 1'b0;
        snap_a   = n_under;
        rx_expq.push_back(16'h5A5A);
        spi_frame(1'b0, 1'b1, 16'h5A5A, 16'h0000, 16, 1'b1);
        check("under_miso_word", 32'(miso_words.pop_front()), 32'h0000);
        check("under_pulses", 32'(n_under - snap_a), 32'd1);
        check("under_drained", 32'(rx_expq.size()), 32'd0);
        tx_valid = 1'b1;

        // Partial frame, then a good frame
        miso_words.delete();
        snap_a = n_ferr;
        snap_b = n_rxv;
        spi_frame(1'b0, 1'b0, 16'hBEEF, 16'h0000, 7, 1'b1);
        check("partial_frame_error", 32'(n_ferr - snap_a), 32'd1);
        check("partial_no_rx_valid", 32'(n_rxv - snap_b), 32'd0);
        check("partial_rx_valid_low", 32'(rx_valid), 32'd0);
        rx_expq.push_back(16'hBEEF);
        spi_frame(1'b0, 1'b0, 16'hBEEF, 16'h0000, 16, 1'b1);
        check("after_partial_drained", 32'(rx_expq.size()), 32'd0);
        check("after_partial_rx_data", 32'(rx_data), 32'hBEEF);

        // Reset mid-word (bit 9), then a clean frame
        miso_words.delete();
        spi_frame(1'b0, 1'b0, 16'hFFFF, 16'h0000, 9, 1'b0);
        reset   = 1'b1;
        spi_cs  = 1'b1;
        spi_sck = 1'b0;
        wait_clk(1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        check("post_rst_rx_valid", 32'(rx_valid), 32'd0);
        snap_a = n_rxv;
        rx_expq.push_back(16'h0F0F);
        spi_frame(1'b0, 1'b0, 16'h0F0F, 16'h0000, 16, 1'b1);
        check("post_rst_rx_data", 32'(rx_data), 32'h0F0F);
        check("post_rst_rx_pulses", 32'(n_rxv - snap_a), 32'd1);

        check("final_drained", 32'(rx_expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
